// File: rtl/pkt_accum_axil.sv
// Packet accumulator: sums signed stream beats per packet and queues the results
// in a small FIFO that is drained and inspected over an AXI-Lite read-only port.
module pkt_accum_axil #(
   parameter int DW           = 32,
   parameter int G_INDX_WIDTH = 10,
   parameter int G_DEPTH      = 16,
   parameter int G_PKT_LEN    = 4,
   parameter bit G_MODE_WRAP  = 1'b1,
   parameter int G_ADDR_WIDTH = 8
) (
   input  logic                    i_clk,
   input  logic                    i_rst,
   input  logic                    s_tvalid,
   output logic                    s_tready,
   input  logic                    s_tlast,
   input  logic signed [DW-1:0]    s_tdata,
   input  logic                    s_axil_arvalid,
   output logic                    s_axil_arready,
   input  logic [G_ADDR_WIDTH-1:0] s_axil_araddr,
   output logic                    s_axil_rvalid,
   input  logic                    s_axil_rready,
   output logic [31:0]             s_axil_rdata,
   output logic [1:0]              s_axil_rresp
);
   localparam int AW  = (G_DEPTH > 1) ? $clog2(G_DEPTH) : 1;
   localparam int WAW = G_ADDR_WIDTH - 2;
   localparam logic [1:0] OKAY = 2'b00, SLVERR = 2'b10;

   typedef logic [AW-1:0] ptr_t;
   typedef struct packed {
      logic [DW-1:0]           sum;
      logic [G_INDX_WIDTH-1:0] idx;
      logic                    err;
      logic [7:0]              cnt;
   } ent_t;

   logic                    rdy_q;
   logic signed [DW-1:0]    acc_q, acc_d, sum_nx;
   logic [7:0]              cnt_q, cnt_d, cnt_nx;
   logic                    cmt_q, cmt_d;
   logic signed [DW-1:0]    csum_q, csum_d;
   logic [7:0]              ccnt_q, ccnt_d;
   logic [G_INDX_WIDTH-1:0] pkt_q, pkt_d;
   ptr_t                    head_q, head_d, tail_q, tail_d;
   logic [AW:0]             fill_q, fill_d;
   logic                    ovf_q, ovf_d;
   logic                    rvalid_q, rvalid_d;
   logic [31:0]             rdata_q, rdata_d;
   logic [1:0]              rresp_q, rresp_d;

   ent_t                    mem [G_DEPTH];
   ent_t                    head_e, new_e;
   logic signed [DW-1:0]    head_sum;
   logic [WAW-1:0]          wa;
   logic                    beat, ar_hs, empty, full, pop, push, ovw, drop, wr_en;
   logic                    unused_addr;

   assign s_tready       = rdy_q;
   assign s_axil_arready = rdy_q & ~rvalid_q;
   assign s_axil_rvalid  = rvalid_q;
   assign s_axil_rdata   = rdata_q;
   assign s_axil_rresp   = rresp_q;

   assign beat        = s_tvalid & rdy_q;
   assign ar_hs       = s_axil_arvalid & s_axil_arready;
   assign wa          = s_axil_araddr[G_ADDR_WIDTH-1:2];
   assign unused_addr = ^s_axil_araddr[1:0];
   assign empty       = (fill_q == '0);
   assign full        = (fill_q == (AW+1)'(G_DEPTH));
   assign head_e      = mem[head_q];
   assign head_sum    = head_e.sum;

   // Accumulator clears on the tlast beat so a new packet can start right behind it.
   always_comb begin
      acc_d  = acc_q;
      cnt_d  = cnt_q;
      cmt_d  = 1'b0;
      csum_d = csum_q;
      ccnt_d = ccnt_q;
      sum_nx = acc_q + s_tdata;
      cnt_nx = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
      if (beat) begin
         if (s_tlast) begin
            cmt_d  = 1'b1;
            csum_d = sum_nx;
            ccnt_d = cnt_nx;
            acc_d  = '0;
            cnt_d  = '0;
         end else begin
            acc_d = sum_nx;
            cnt_d = cnt_nx;
         end
      end
   end

   // A pop in the same cycle frees a slot, so a full FIFO then takes a plain push.
   always_comb begin
      pop    = ar_hs && (wa == WAW'(2)) && !empty;
      push   = cmt_q && (!full || pop);
      ovw    = cmt_q && full && !pop && G_MODE_WRAP;
      drop   = cmt_q && full && !pop && !G_MODE_WRAP;
      wr_en  = push | ovw;
      new_e  = '{sum: csum_q, idx: pkt_q, err: (ccnt_q != 8'(G_PKT_LEN)), cnt: ccnt_q};
      pkt_d  = cmt_q ? pkt_q + 1'b1 : pkt_q;
      tail_d = wr_en ? tail_q + ptr_t'(1) : tail_q;
      head_d = (pop | ovw) ? head_q + ptr_t'(1) : head_q;
      fill_d = fill_q;
      if (push && !pop)      fill_d = fill_q + 1'b1;
      else if (pop && !push) fill_d = fill_q - 1'b1;

      rvalid_d = rvalid_q;
      rdata_d  = rdata_q;
      rresp_d  = rresp_q;
      ovf_d    = ovf_q;
      if (rvalid_q && s_axil_rready) rvalid_d = 1'b0;
      if (ar_hs) begin
         rvalid_d = 1'b1;
         rdata_d  = '0;
         rresp_d  = SLVERR;
         case (wa)
            WAW'(0): begin
               rdata_d = {21'b0, ovf_q, empty, full, 8'(fill_q)};
               rresp_d = OKAY;
               ovf_d   = 1'b0;
            end
            WAW'(1): begin
               rdata_d = 32'(pkt_q);
               rresp_d = OKAY;
            end
            WAW'(2): if (!empty) begin
               rdata_d = 32'(head_sum);
               rresp_d = OKAY;
            end
            WAW'(3): if (!empty) begin
               rdata_d = {16'(head_e.idx), 7'b0, head_e.err, head_e.cnt};
               rresp_d = OKAY;
            end
            default: ;
         endcase
      end
      if (ovw | drop) ovf_d = 1'b1;
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         rdy_q    <= 1'b0;
         acc_q    <= '0;
         cnt_q    <= '0;
         cmt_q    <= 1'b0;
         csum_q   <= '0;
         ccnt_q   <= '0;
         pkt_q    <= '0;
         head_q   <= '0;
         tail_q   <= '0;
         fill_q   <= '0;
         ovf_q    <= 1'b0;
         rvalid_q <= 1'b0;
         rdata_q  <= '0;
         rresp_q  <= '0;
      end else begin
         rdy_q    <= 1'b1;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         cmt_q    <= cmt_d;
         csum_q   <= csum_d;
         ccnt_q   <= ccnt_d;
         pkt_q    <= pkt_d;
         head_q   <= head_d;
         tail_q   <= tail_d;
         fill_q   <= fill_d;
         ovf_q    <= ovf_d;
         rvalid_q <= rvalid_d;
         rdata_q  <= rdata_d;
         rresp_q  <= rresp_d;
      end
   end

   always_ff @(posedge i_clk) begin
      if (wr_en) mem[tail_q] <= new_e;
   end
endmodule
